ysyx_25040129_mdu: RTL and testbench

Iterative RV32M multiply/divide unit and its sequencing controller, sitting beside the single-cycle EXU ALU on the IDU→EXU→LSU path. It accepts one M-extension operation per handshake from IDU, runs a 32-step shift-add (multiply) or restoring-subtract (divide) loop, applies sign correction, and holds the result under a valid/ready handshake toward LSU. It owns its operand, accumulator and counter registers; only one operation is in flight at a time.

---
 rtl/ysyx_25040129_mdu_pkg.sv | 34 +++
 rtl/ysyx_25040129_mdu_datapath.sv | 93 +++++++++
 rtl/ysyx_25040129_mdu.sv | 154 +++++++++++++++
 tb/tb_ysyx_25040129_mdu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_mdu_pkg.sv
// ysyx_25040129 MDU shared defines: funct3 opcodes, FSM states, sign decode.
// Optional build macro: YSYX_25040129_MDU_FAST_MUL_EN (single-cycle multiply).
package ysyx_25040129_mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic src1_signed(mdu_op_e op);
    return op == OP_MULH || op == OP_MULHSU ||
           op == OP_DIV  || op == OP_REM;
  endfunction

  function automatic logic src2_signed(mdu_op_e op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction

endpackage

// File: rtl/ysyx_25040129_mdu_datapath.sv
// MDU datapath: operand/accumulator registers, one shift-add or
// restoring shift-subtract step per enable, final sign-fix mux.
module ysyx_25040129_mdu_datapath
  import ysyx_25040129_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic            set_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] set_val_i,
  input  logic            neg_q_i,
  input  logic            neg_r_i,
  input  mdu_op_e         op_i,
  output logic [XLEN-1:0] res_o
);

  logic [63:0] acc_q, acc_d;
  logic [63:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;

  logic [32:0] sh;
  logic [33:0] diff;
  logic [63:0] prod;
  logic [31:0] quo, rem, fix_val;

  // acc holds the product, or {remainder, dividend->quotient} when dividing
  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    sh    = {acc_q[63:32], acc_q[31]};
    diff  = {1'b0, sh} - {2'b0, opa_q[31:0]};
    if (load_i) begin
      if (is_div_i) begin
        acc_d = {32'b0, a_i};
        opa_d = {32'b0, b_i};
        opb_d = '0;
      end else begin
        acc_d = '0;
        opa_d = {32'b0, a_i};
        opb_d = b_i;
      end
    end else if (step_i) begin
      if (is_div_i) begin
        if (!diff[33]) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
        else           acc_d = {sh[31:0], acc_q[30:0], 1'b0};
      end else begin
        acc_d = acc_q + (opb_q[0] ? opa_q : 64'b0);
        opa_d = {opa_q[62:0], 1'b0};
        opb_d = {1'b0, opb_q[31:1]};
      end
    end
  end

  always_comb begin
    prod = neg_q_i ? -acc_q : acc_q;
    quo  = neg_q_i ? -acc_q[31:0] : acc_q[31:0];
    rem  = neg_r_i ? -acc_q[63:32] : acc_q[63:32];
    unique case (op_i)
      OP_MUL:                        fix_val = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[63:32];
      OP_DIV, OP_DIVU:               fix_val = quo;
      OP_REM, OP_REMU:               fix_val = rem;
      default:                       fix_val = '0;
    endcase
    res_d = res_q;
    if (set_i)      res_d = set_val_i;
    else if (fix_i) res_d = fix_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/ysyx_25040129_mdu.sv
// Iterative RV32M multiply/divide unit: FSM, handshakes, special cases.
// YSYX_25040129_MDU_FAST_MUL_EN selects a single-cycle multiply path.
module ysyx_25040129_mdu
  import ysyx_25040129_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] src1_in,
  input  logic [XLEN-1:0] src2_in,
  input  logic [4:0]      rd_in,
  input  logic            flush_in,
  output logic            resp_valid_out,
  input  logic            resp_ready_in,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            busy_out
);

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q, op_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d;
  logic       negq_q, negq_d;
  logic       negr_q, negr_d;

  mdu_op_e     op;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic        div_zero, div_ovf, is_rem;
  logic [31:0] special_val, set_val;
  logic        load, step, fix, set;

  assign op       = mdu_op_e'(op_in);
  assign a_neg    = src1_signed(op) & src1_in[31];
  assign b_neg    = src2_signed(op) & src2_in[31];
  assign a_abs    = a_neg ? -src1_in : src1_in;
  assign b_abs    = b_neg ? -src2_in : src2_in;
  assign is_rem   = op_in[1];
  assign div_zero = op_in[2] && src2_in == 32'h0;
  assign div_ovf  = (op == OP_DIV || op == OP_REM) &&
                    src1_in == 32'h8000_0000 &&
                    src2_in == 32'hFFFF_FFFF;

  always_comb begin
    special_val = '0;
    if (div_zero)     special_val = is_rem ? src1_in : 32'hFFFF_FFFF;
    else if (div_ovf) special_val = is_rem ? 32'h0 : 32'h8000_0000;
  end

`ifdef YSYX_25040129_MDU_FAST_MUL_EN
  logic signed [63:0] fprod;
  logic [31:0]        fast_val;
  // 33-bit operands carry the per-op sign so one signed multiply covers all
  assign fprod    = $signed({src1_signed(op) & src1_in[31], src1_in}) *
                    $signed({src2_signed(op) & src2_in[31], src2_in});
  assign fast_val = (op == OP_MUL) ? fprod[31:0] : fprod[63:32];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    set     = 1'b0;
    set_val = special_val;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_in && !flush_in) begin
          op_d   = op;
          rd_d   = rd_in;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            set     = 1'b1;
            state_d = S_DONE;
`ifdef YSYX_25040129_MDU_FAST_MUL_EN
          end else if (!op_in[2]) begin
            set     = 1'b1;
            set_val = fast_val;
            state_d = S_DONE;
`endif
          end else begin
            load    = 1'b1;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        step  = !flush_in;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        fix     = !flush_in;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_in) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      rd_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  ysyx_25040129_mdu_datapath u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_i    (step),
    .fix_i     (fix),
    .set_i     (set),
    .is_div_i  (op_d[2]),
    .a_i       (a_abs),
    .b_i       (b_abs),
    .set_val_i (set_val),
    .neg_q_i   (negq_q),
    .neg_r_i   (negr_q),
    .op_i      (op_q),
    .res_o     (result_out)
  );

  assign req_ready_out  = state_q == S_IDLE;
  assign busy_out       = state_q != S_IDLE;
  assign resp_valid_out = state_q == S_DONE;
  assign rd_out         = rd_q;

endmodule

// File: tb/tb_ysyx_25040129_mdu.sv
// Self-checking bench for ysyx_25040129_mdu: directed RV32M cases,
// random ops against an arithmetic reference, flush/reset/back-pressure.
module tb_ysyx_25040129_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [2:0]  op_in;
  logic [31:0] src1_in, src2_in;
  logic [4:0]  rd_in;
  logic        flush_in;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] result_out;
  logic [4:0]  rd_out;
  logic        busy_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25040129_mdu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .op_in          (op_in),
    .src1_in        (src1_in),
    .src2_in        (src2_in),
    .rd_in          (rd_in),
    .flush_in       (flush_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .result_out     (result_out),
    .rd_out         (rd_out),
    .busy_out       (busy_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_res(logic [2:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] op, logic [31:0] a,
                                 logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
`ifdef YSYX_25040129_MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_res(op, a, b);
    chk({tag, " ready"}, req_ready_out, 1);
    req_valid_in = 1'b1;
    op_in = op;
    src1_in = a;
    src2_in = b;
    rd_in = rd;
    tick;
    req_valid_in = 1'b0;
    src1_in = $urandom;
    src2_in = $urandom;
    rd_in = 5'($urandom);
    lat = 1;
    while (!resp_valid_out && lat < 100) begin
      tick;
      lat++;
    end
    chk({tag, " valid"}, resp_valid_out, 1);
    chk({tag, " latency"}, lat, ref_lat(op, a, b));
    chk({tag, " result"}, result_out, exp);
    chk({tag, " rd"}, rd_out, rd);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, " hold result"}, result_out, exp);
      chk({tag, " hold rd"}, rd_out, rd);
      chk({tag, " hold ready"}, req_ready_out, 0);
      chk({tag, " hold valid"}, resp_valid_out, 1);
    end
    resp_ready_in = 1'b1;
    tick;
    resp_ready_in = 1'b0;
    chk({tag, " post valid"}, resp_valid_out, 0);
    chk({tag, " post busy"}, busy_out, 0);
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    logic saw_valid;
    rst_n = 1'b0;
    req_valid_in = 1'b0;
    op_in = '0;
    src1_in = '0;
    src2_in = '0;
    rd_in = '0;
    flush_in = 1'b0;
    resp_ready_in = 1'b0;
    tick;
    tick;
    chk("rst ready", req_ready_out, 1);
    chk("rst valid", resp_valid_out, 0);
    chk("rst busy", busy_out, 0);
    chk("rst result", result_out, 0);
    chk("rst rd", rd_out, 0);
    rst_n = 1'b1;
    tick;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 0);
    run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd11, 0);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd12, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
    run_op("bp", 3'd1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd15, 10);
    run_op("after bp", 3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd16, 0);

    req_valid_in = 1'b1;
    op_in = 3'd5;
    src1_in = 32'hFFFF_0000;
    src2_in = 32'd3;
    rd_in = 5'd17;
    tick;
    req_valid_in = 1'b0;
    repeat (10) tick;
    chk("flush pre busy", busy_out, 1);
    flush_in = 1'b1;
    resp_ready_in = 1'b1;
    tick;
    flush_in = 1'b0;
    resp_ready_in = 1'b0;
    chk("flush busy", busy_out, 0);
    chk("flush ready", req_ready_out, 1);
    saw_valid = resp_valid_out;
    repeat (40) begin
      tick;
      saw_valid |= resp_valid_out;
    end
    chk("flush no resp", saw_valid, 0);
    run_op("post flush", 3'd5, 32'd9, 32'd3, 5'd18, 0);

    req_valid_in = 1'b1;
    flush_in = 1'b1;
    op_in = 3'd0;
    tick;
    req_valid_in = 1'b0;
    flush_in = 1'b0;
    chk("flush vs accept", busy_out, 0);

    req_valid_in = 1'b1;
    op_in = 3'd7;
    src1_in = 32'd5;
    src2_in = 32'd0;
    rd_in = 5'd19;
    tick;
    req_valid_in = 1'b0;
    chk("done pre flush", resp_valid_out, 1);
    flush_in = 1'b1;
    tick;
    flush_in = 1'b0;
    chk("done flush valid", resp_valid_out, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0, 1:    rb = 32'h0;
        2, 3:    rb = 32'($urandom_range(1, 255));
        4:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        5:       ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op($sformatf("rand%0d", n), rop, ra, rb, 5'($urandom), 0);
    end

    req_valid_in = 1'b1;
    op_in = 3'd0;
    src1_in = 32'd3;
    src2_in = 32'd5;
    rd_in = 5'd20;
    tick;
    req_valid_in = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    chk("mid rst result", result_out, 0);
    chk("mid rst rd", rd_out, 0);
    chk("mid rst busy", busy_out, 0);
    chk("mid rst valid", resp_valid_out, 0);
    rst_n = 1'b1;
    tick;
    run_op("after rst", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd21, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
